// File: rtl/cq_viola_nios2_s_ocimem_pkg.sv
// ----------------------------------------------------------------------------
// cq_viola_nios2_s_ocimem_pkg
// Shared definitions for the OCI debug-RAM controller:
//   - ocimem_state_e : controller FSM states
//   - jdo field positions (address [25:18], write data [35:4])
//   - RAM_AW         : debug RAM address width (8 bits, up to 256 words)
//   - addr_out_of_range() : address vs. implemented depth check
// ----------------------------------------------------------------------------
package cq_viola_nios2_s_ocimem_pkg;

    localparam int RAM_AW        = 8;
    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_MSB  = 25;
    localparam int JDO_ADDR_LSB  = 18;
    localparam int JDO_WDATA_MSB = 35;
    localparam int JDO_WDATA_LSB = 4;

    typedef enum logic [2:0] {
        ST_IDLE,   // free: may start a JTAG op or serve the CPU
        ST_JRD,    // JTAG read: RAM address driven
        ST_JCAP,   // JTAG read: RAM data captured into MonDReg
        ST_JWR,    // JTAG write: RAM write strobe
        ST_CRD     // CPU read: RAM data returned to the CPU
    } ocimem_state_e;

    function automatic logic addr_out_of_range(input logic [RAM_AW-1:0] addr,
                                               input int depth);
        return int'(addr) >= depth;
    endfunction

endpackage

// File: rtl/cq_viola_nios2_s_ocimem_arb.sv
// ----------------------------------------------------------------------------
// cq_viola_nios2_s_ocimem_arb
// One-slot pending register for JTAG read/write commands plus JTAG/CPU grant.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   rd_cmd, wr_cmd    : JTAG read / write command pulses
//   state             : controller FSM state
//   cpu_read/write    : CPU debug slave request
//   pend_valid/write  : pending command present / it is a write
//   cmd_accept        : incoming pulse latched into the slot this cycle
//   cmd_drop          : incoming pulse discarded (slot or FSM busy)
//   cpu_rd/wr_grant   : CPU owns the RAM this cycle
// ----------------------------------------------------------------------------
module cq_viola_nios2_s_ocimem_arb
    import cq_viola_nios2_s_ocimem_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          rd_cmd,
    input  logic          wr_cmd,
    input  ocimem_state_e state,
    input  logic          cpu_read,
    input  logic          cpu_write,
    output logic          pend_valid,
    output logic          pend_write,
    output logic          cmd_accept,
    output logic          cmd_drop,
    output logic          cpu_rd_grant,
    output logic          cpu_wr_grant
);

    logic pend_valid_reg;
    logic pend_write_reg;
    logic any_cmd;
    logic cmd_busy;
    logic fsm_idle;
    logic cpu_free;

    assign fsm_idle = (state == ST_IDLE);
    assign any_cmd  = rd_cmd | wr_cmd;
    // A JTAG op counts as busy from the moment it is queued until it retires.
    assign cmd_busy = pend_valid_reg | (state == ST_JRD) | (state == ST_JCAP)
                    | (state == ST_JWR);

    assign cmd_accept = any_cmd & ~cmd_busy;
    assign cmd_drop   = any_cmd & cmd_busy;

    // JTAG wins: an arriving pulse already blocks the CPU in the same cycle.
    assign cpu_free     = ~reset & fsm_idle & ~pend_valid_reg & ~any_cmd;
    assign cpu_rd_grant = cpu_free & cpu_read;
    assign cpu_wr_grant = cpu_free & cpu_write & ~cpu_read;

    assign pend_valid = pend_valid_reg;
    assign pend_write = pend_write_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_reg <= 1'b0;
            pend_write_reg <= 1'b0;
        end else if (cmd_accept) begin
            pend_valid_reg <= 1'b1;
            // Simultaneous read and write pulses collapse into the write.
            pend_write_reg <= wr_cmd;
        end else if (fsm_idle & pend_valid_reg) begin
            // The FSM leaves IDLE for the pending op on this edge.
            pend_valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/cq_viola_nios2_s_ocimem_ctrl.sv
// ----------------------------------------------------------------------------
// cq_viola_nios2_s_ocimem_ctrl
// Executes JTAG debug-module RAM commands (address load / read / write) and a
// CPU debug slave port on one single-port RAM with 1-cycle registered reads.
// Optional feature: define CQ_VIOLA_OCIMEM_AUTOINC_EN to post-increment
// MonAReg after every executed JTAG read or write (wraps 8'hFF -> 8'h00).
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   jdo, take_*_ocimem_*              : JTAG payload and command pulses
//   MonDReg, monitor_ready/error      : JTAG result, completion, sticky error
//   cpu_address/read/write/writedata  : CPU request
//   cpu_readdata, cpu_waitrequest     : CPU response
//   ram_addr/wren/wrdata, ram_rddata  : RAM port
// ----------------------------------------------------------------------------
module cq_viola_nios2_s_ocimem_ctrl
    import cq_viola_nios2_s_ocimem_pkg::*;
#(
    parameter int RAM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [RAM_AW-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_wren,
    output logic [31:0]       ram_wrdata,
    input  logic [31:0]       ram_rddata
);

    ocimem_state_e     state_reg;
    logic [RAM_AW-1:0] mon_a_reg;
    logic [RAM_AW-1:0] mon_a_next;
    logic [31:0]       mon_d_reg;
    logic              monitor_ready_reg;
    logic              monitor_error_reg;
    logic              jrd_oob_reg;
    logic              cpu_oob_reg;

    logic pend_valid, pend_write, cmd_accept, cmd_drop;
    logic cpu_rd_grant, cpu_wr_grant;
    logic jtag_oob, cpu_oob;

    // Payload bits outside the address and write-data fields carry nothing here.
    logic jdo_unused;
    assign jdo_unused = ^{jdo[JDO_W-1:JDO_WDATA_MSB+1], jdo[JDO_WDATA_LSB-1:0]};

    assign jtag_oob = addr_out_of_range(mon_a_reg, RAM_DEPTH);
    assign cpu_oob  = addr_out_of_range(cpu_address, RAM_DEPTH);

`ifdef CQ_VIOLA_OCIMEM_AUTOINC_EN
    assign mon_a_next = mon_a_reg + RAM_AW'(1);
`else
    assign mon_a_next = mon_a_reg;
`endif

    cq_viola_nios2_s_ocimem_arb u_arb (
        .clk          (clk),
        .reset        (reset),
        .rd_cmd       (take_no_action_ocimem_a),
        .wr_cmd       (take_action_ocimem_b),
        .state        (state_reg),
        .cpu_read     (cpu_read),
        .cpu_write    (cpu_write),
        .pend_valid   (pend_valid),
        .pend_write   (pend_write),
        .cmd_accept   (cmd_accept),
        .cmd_drop     (cmd_drop),
        .cpu_rd_grant (cpu_rd_grant),
        .cpu_wr_grant (cpu_wr_grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            mon_a_reg         <= '0;
            mon_d_reg         <= '0;
            monitor_ready_reg <= 1'b1;
            monitor_error_reg <= 1'b0;
            jrd_oob_reg       <= 1'b0;
            cpu_oob_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pend_valid) begin
                        state_reg <= pend_write ? ST_JWR : ST_JRD;
                    end else if (cpu_rd_grant) begin
                        state_reg   <= ST_CRD;
                        cpu_oob_reg <= cpu_oob;
                    end
                end
                ST_JRD: begin
                    // Range decision is frozen here; JCAP only sees the data.
                    jrd_oob_reg <= jtag_oob;
                    state_reg   <= ST_JCAP;
                end
                ST_JCAP: begin
                    if (jrd_oob_reg) begin
                        monitor_error_reg <= 1'b1;
                    end else begin
                        mon_d_reg <= ram_rddata;
                    end
                    monitor_ready_reg <= 1'b1;
                    mon_a_reg         <= mon_a_next;
                    state_reg         <= ST_IDLE;
                end
                ST_JWR: begin
                    if (jtag_oob) begin
                        monitor_error_reg <= 1'b1;
                    end
                    monitor_ready_reg <= 1'b1;
                    mon_a_reg         <= mon_a_next;
                    state_reg         <= ST_IDLE;
                end
                ST_CRD: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            // An explicit address load overrides any post-increment.
            if (take_action_ocimem_a) begin
                mon_a_reg         <= jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
                monitor_error_reg <= 1'b0;
            end
            if (cmd_accept) begin
                monitor_ready_reg <= 1'b0;
                if (take_action_ocimem_b) begin
                    mon_d_reg <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
                end
            end
            if (cmd_drop) begin
                monitor_error_reg <= 1'b1;
            end
        end
    end

    // RAM and CPU response are decoded from the current state; everything is
    // forced to its idle value while reset is high so no write can slip out.
    always_comb begin
        ram_addr        = '0;
        ram_wren        = 1'b0;
        ram_wrdata      = '0;
        cpu_waitrequest = 1'b1;
        cpu_readdata    = '0;
        if (!reset) begin
            case (state_reg)
                ST_IDLE: begin
                    if (cpu_wr_grant) begin
                        ram_addr        = cpu_oob ? '0 : cpu_address;
                        ram_wren        = ~cpu_oob;
                        ram_wrdata      = cpu_writedata;
                        cpu_waitrequest = 1'b0;
                    end else if (cpu_rd_grant) begin
                        ram_addr = cpu_oob ? '0 : cpu_address;
                    end
                end
                ST_JRD: begin
                    ram_addr = jtag_oob ? '0 : mon_a_reg;
                end
                ST_JWR: begin
                    ram_addr   = jtag_oob ? '0 : mon_a_reg;
                    ram_wren   = ~jtag_oob;
                    ram_wrdata = mon_d_reg;
                end
                ST_CRD: begin
                    cpu_waitrequest = 1'b0;
                    cpu_readdata    = cpu_oob_reg ? '0 : ram_rddata;
                end
                default: begin
                    ram_addr = '0;
                end
            endcase
        end
    end

    assign MonDReg       = mon_d_reg;
    assign monitor_ready = monitor_ready_reg;
    assign monitor_error = monitor_error_reg;

endmodule

// File: tb/tb_cq_viola_nios2_s_ocimem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cq_viola_nios2_s_ocimem_ctrl
// Drives JTAG commands and CPU accesses into the controller with a behavioural
// RAM attached, and checks results against an abstract model of the debug RAM
// (word array, address register, data register, sticky error flag).
// ----------------------------------------------------------------------------
module tb_cq_viola_nios2_s_ocimem_ctrl;

    localparam int DEPTH = 128;
`ifdef CQ_VIOLA_OCIMEM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;
    logic [7:0]  cpu_address = '0;
    logic        cpu_read = 1'b0, cpu_write = 1'b0;
    logic [31:0] cpu_writedata = '0;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [31:0] ram_wrdata;
    logic [31:0] ram_rddata = '0;

    int n_cmp = 0;
    int n_fail = 0;

    // Behavioural single-port RAM, registered read.
    logic [31:0] env_mem [256];
    // Reference model state.
    logic [31:0] ref_mem [256];
    logic [7:0]  ref_a;
    logic [31:0] ref_d;
    logic        ref_err;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) env_mem[ram_addr] <= ram_wrdata;
        ram_rddata <= env_mem[ram_addr];
    end

    cq_viola_nios2_s_ocimem_ctrl #(.RAM_DEPTH(DEPTH)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_wrdata              (ram_wrdata),
        .ram_rddata              (ram_rddata)
    );

    // ---------------- drivers and model ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        ref_a = '0; ref_d = '0; ref_err = 1'b0;
    endtask

    task automatic model_write(input logic [31:0] d);
        ref_d = d;
        if (int'(ref_a) < DEPTH) ref_mem[ref_a] = d;
        else ref_err = 1'b1;
        if (AUTOINC) ref_a = ref_a + 8'd1;
    endtask

    task automatic model_read;
        if (int'(ref_a) < DEPTH) ref_d = ref_mem[ref_a];
        else ref_err = 1'b1;
        if (AUTOINC) ref_a = ref_a + 8'd1;
    endtask

    task automatic jtag_addr(input logic [7:0] a);
        jdo = {6'($urandom), 32'($urandom)};
        jdo[25:18] = a;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        ref_a = a; ref_err = 1'b0;
        $display("jtag addr  0x%02h", a);
    endtask

    task automatic pulse_write(input logic [31:0] d);
        jdo = {6'($urandom), 32'($urandom)};
        jdo[35:4] = d;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        $display("jtag write 0x%08h", d);
    endtask

    task automatic pulse_read;
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        $display("jtag read");
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (monitor_ready) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, output bit ok);
        cpu_address = a; cpu_writedata = d; cpu_write = 1'b1; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!cpu_waitrequest) begin ok = 1'b1; tick(); break; end
            tick();
        end
        cpu_write = 1'b0;
        if (int'(a) < DEPTH) ref_mem[a] = d;
        $display("cpu  write 0x%02h <= 0x%08h", a, d);
    endtask

    task automatic cpu_rd(input logic [7:0] a, output logic [31:0] d, output bit ok);
        cpu_address = a; cpu_read = 1'b1; ok = 1'b0; d = '0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!cpu_waitrequest) begin ok = 1'b1; d = cpu_readdata; tick(); break; end
            tick();
        end
        cpu_read = 1'b0;
        $display("cpu  read  0x%02h => 0x%08h", a, d);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1;
        cpu_read = 1'b1; cpu_address = 8'h03;
        tick(); tick();
        n_cmp++; if (cpu_waitrequest !== 1'b1) begin n_fail++; $display("FAIL reset_waitreq: got %b want 1", cpu_waitrequest); end
        n_cmp++; if (ram_wren !== 1'b0 || ram_addr !== 8'h00) begin n_fail++; $display("FAIL reset_ram: got wren=%b addr=%h want 0/00", ram_wren, ram_addr); end
        n_cmp++; if (MonDReg !== 32'h0) begin n_fail++; $display("FAIL reset_mondreg: got %h want 0", MonDReg); end
        n_cmp++; if (monitor_ready !== 1'b1 || monitor_error !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got rdy=%b err=%b want 1/0", monitor_ready, monitor_error); end
        n_cmp++; if (cpu_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got %h want 0", cpu_readdata); end
        cpu_read = 1'b0;
        reset = 1'b0;
        tick();
        model_reset();
        $display("reset done");
    endtask

    task automatic test_basic;
        bit ok;
        jtag_addr(8'h10);
        pulse_write(32'hDEADBEEF);
        n_cmp++; if (monitor_ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready_low: got %b want 0", monitor_ready); end
        tick();
        n_cmp++; if ({ram_wren, ram_addr, ram_wrdata} !== {1'b1, 8'h10, 32'hDEADBEEF}) begin n_fail++; $display("FAIL wr_jwr_cycle: got wren=%b addr=%h data=%h want 1/10/deadbeef", ram_wren, ram_addr, ram_wrdata); end
        tick();
        n_cmp++; if (monitor_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_high: got %b want 1", monitor_ready); end
        model_write(32'hDEADBEEF);
        jtag_addr(8'h10);
        pulse_read();
        n_cmp++; if (monitor_ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_low: got %b want 0", monitor_ready); end
        tick();
        n_cmp++; if (ram_addr !== 8'h10 || ram_wren !== 1'b0) begin n_fail++; $display("FAIL rd_jrd_addr: got addr=%h wren=%b want 10/0", ram_addr, ram_wren); end
        tick();
        n_cmp++; if (monitor_ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_jcap: got %b want 0", monitor_ready); end
        tick();
        model_read();
        n_cmp++; if (MonDReg !== ref_d || monitor_ready !== 1'b1) begin n_fail++; $display("FAIL rd_result: got %h rdy=%b want %h rdy=1", MonDReg, monitor_ready, ref_d); end
        wait_ready(ok);
    endtask

    task automatic test_out_of_range;
        bit ok, saw_wren;
        jtag_addr(8'h80);
        n_cmp++; if (monitor_error !== 1'b0) begin n_fail++; $display("FAIL oob_pre_err: got %b want 0", monitor_error); end
        pulse_read();
        saw_wren = 1'b0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ram_wren) saw_wren = 1'b1;
            if (monitor_ready) begin ok = 1'b1; break; end
            tick();
        end
        model_read();
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL oob_rd_timeout: got no ready want ready"); end
        n_cmp++; if (MonDReg !== ref_d || monitor_error !== 1'b1 || saw_wren) begin n_fail++; $display("FAIL oob_rd: got d=%h err=%b wren=%b want d=%h err=1 wren=0", MonDReg, monitor_error, saw_wren, ref_d); end
        pulse_write(32'h1234_5678);
        saw_wren = 1'b0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ram_wren) saw_wren = 1'b1;
            if (monitor_ready) begin ok = 1'b1; break; end
            tick();
        end
        model_write(32'h1234_5678);
        n_cmp++; if (!ok || saw_wren || monitor_error !== 1'b1) begin n_fail++; $display("FAIL oob_wr: got rdy=%b wren=%b err=%b want 1/0/1", ok, saw_wren, monitor_error); end
        jtag_addr(8'h00);
        n_cmp++; if (monitor_error !== 1'b0) begin n_fail++; $display("FAIL oob_clear: got %b want 0", monitor_error); end
    endtask

    task automatic test_arbitration;
        logic [31:0] d;
        jtag_addr(8'h05);
        d = $urandom;
        cpu_address = 8'h05; cpu_read = 1'b1;
        jdo = {6'($urandom), 32'($urandom)};
        jdo[35:4] = d;
        take_action_ocimem_b = 1'b1;
        #1;
        n_cmp++; if (cpu_waitrequest !== 1'b1) begin n_fail++; $display("FAIL arb_same_cycle: got waitreq=%b want 1", cpu_waitrequest); end
        tick();
        take_action_ocimem_b = 1'b0;
        #1;
        n_cmp++; if (cpu_waitrequest !== 1'b1) begin n_fail++; $display("FAIL arb_pending: got waitreq=%b want 1", cpu_waitrequest); end
        tick();
        n_cmp++; if (ram_wren !== 1'b1 || ram_addr !== 8'h05 || cpu_waitrequest !== 1'b1) begin n_fail++; $display("FAIL arb_jwr: got wren=%b addr=%h wait=%b want 1/05/1", ram_wren, ram_addr, cpu_waitrequest); end
        model_write(d);
        tick();
        n_cmp++; if (cpu_waitrequest !== 1'b1) begin n_fail++; $display("FAIL arb_cpu_grant: got waitreq=%b want 1", cpu_waitrequest); end
        tick();
        n_cmp++; if (cpu_waitrequest !== 1'b0 || cpu_readdata !== ref_mem[5]) begin n_fail++; $display("FAIL arb_cpu_data: got wait=%b data=%h want 0/%h", cpu_waitrequest, cpu_readdata, ref_mem[5]); end
        tick();
        cpu_read = 1'b0;
        $display("arb: jtag write 0x%08h then cpu read 0x05", d);
    endtask

    task automatic test_drop;
        bit ok;
        logic [31:0] x;
        int low_cycles;
        x = $urandom;
        cpu_wr(8'h02, x, ok);
        jtag_addr(8'h02);
        pulse_read();
        tick();
        pulse_read();
        n_cmp++; if (monitor_error !== 1'b1) begin n_fail++; $display("FAIL drop_err: got %b want 1", monitor_error); end
        wait_ready(ok);
        model_read();
        ref_err = 1'b1;
        n_cmp++; if (!ok || MonDReg !== ref_d || monitor_error !== 1'b1) begin n_fail++; $display("FAIL drop_result: got rdy=%b d=%h err=%b want 1/%h/1", ok, MonDReg, monitor_error, ref_d); end
        low_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!monitor_ready) low_cycles++;
        end
        n_cmp++; if (low_cycles != 0) begin n_fail++; $display("FAIL drop_no_second_op: got %0d busy cycles want 0", low_cycles); end
    endtask

    task automatic test_addr_step;
        bit ok;
        logic [7:0] exp_addr;
        cpu_wr(8'h00, 32'h0000_A5A5, ok);
        jtag_addr(8'hFF);
        pulse_write(32'h0000_0001);
        wait_ready(ok);
        model_write(32'h0000_0001);
        exp_addr = (int'(ref_a) < DEPTH) ? ref_a : 8'h00;
        pulse_read();
        tick();
        n_cmp++; if (ram_addr !== exp_addr) begin n_fail++; $display("FAIL step_rd_addr: got %h want %h", ram_addr, exp_addr); end
        wait_ready(ok);
        model_read();
        n_cmp++; if (!ok || MonDReg !== ref_d || monitor_error !== ref_err) begin n_fail++; $display("FAIL step_result: got rdy=%b d=%h err=%b want 1/%h/%b", ok, MonDReg, monitor_error, ref_d, ref_err); end
    endtask

    task automatic test_random;
        bit ok;
        logic [31:0] d, rd;
        logic [7:0] a;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0: begin
                    jtag_addr(8'($urandom_range(0, 159)));
                    n_cmp++; if (monitor_error !== 1'b0) begin n_fail++; $display("FAIL rnd_addr_err: got %b want 0", monitor_error); end
                end
                1: begin
                    d = $urandom;
                    pulse_write(d);
                    wait_ready(ok);
                    model_write(d);
                    n_cmp++; if (!ok || MonDReg !== ref_d || monitor_error !== ref_err) begin n_fail++; $display("FAIL rnd_jwr: got rdy=%b d=%h err=%b want 1/%h/%b", ok, MonDReg, monitor_error, ref_d, ref_err); end
                end
                2: begin
                    pulse_read();
                    wait_ready(ok);
                    model_read();
                    n_cmp++; if (!ok || MonDReg !== ref_d || monitor_error !== ref_err) begin n_fail++; $display("FAIL rnd_jrd: got rdy=%b d=%h err=%b want 1/%h/%b", ok, MonDReg, monitor_error, ref_d, ref_err); end
                end
                3: begin
                    a = 8'($urandom); d = $urandom;
                    cpu_wr(a, d, ok);
                    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rnd_cpu_wr: got no grant want grant"); end
                end
                default: begin
                    a = (it % 2 == 0) ? ref_a : 8'($urandom);
                    cpu_rd(a, rd, ok);
                    d = (int'(a) < DEPTH) ? ref_mem[a] : 32'h0;
                    n_cmp++; if (!ok || rd !== d) begin n_fail++; $display("FAIL rnd_cpu_rd: got ok=%b data=%h want 1/%h", ok, rd, d); end
                end
            endcase
        end
    endtask

    task automatic test_reset_mid_write;
        bit ok;
        jtag_addr(8'h07);
        pulse_write(32'hCAFE_F00D);
        tick();
        n_cmp++; if (ram_wren !== 1'b1) begin n_fail++; $display("FAIL rst_mid_jwr: got wren=%b want 1", ram_wren); end
        reset = 1'b1;
        #1;
        n_cmp++; if (ram_wren !== 1'b0 || ram_addr !== 8'h00 || cpu_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_mid_gate: got wren=%b addr=%h wait=%b want 0/00/1", ram_wren, ram_addr, cpu_waitrequest); end
        tick();
        n_cmp++; if (MonDReg !== 32'h0 || monitor_ready !== 1'b1 || monitor_error !== 1'b0 || cpu_readdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_outputs: got d=%h rdy=%b err=%b rdata=%h want 0/1/0/0", MonDReg, monitor_ready, monitor_error, cpu_readdata); end
        reset = 1'b0;
        tick();
        model_reset();
        n_cmp++; if (env_mem[7] !== ref_mem[7]) begin n_fail++; $display("FAIL rst_mid_suppressed: got mem[7]=%h want %h", env_mem[7], ref_mem[7]); end
        pulse_read();
        wait_ready(ok);
        model_read();
        n_cmp++; if (!ok || MonDReg !== ref_d) begin n_fail++; $display("FAIL rst_post_read: got rdy=%b d=%h want 1/%h", ok, MonDReg, ref_d); end
        $display("reset during jtag write");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = '0;
            ref_mem[i] = '0;
        end
        model_reset();
        test_reset();
        test_basic();
        test_out_of_range();
        test_arbitration();
        test_drop();
        test_addr_step();
        test_random();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
